// File: rtl/heartbeat_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : heartbeat_scheduler
//  Purpose  : Periodic scheduler for heartbeat generators sharing one TX
//             stream. One free-running period counter per channel raises a
//             pending request. A single-slot FSM grants pending channels
//             round-robin, only while the link is idle, and waits for each
//             packet to finish or for the watchdog to expire.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             enable            - global run; low clears counters/pending
//             cfg_period        - per-channel period, 0 disables a channel
//             link_idle         - shared stream has no packet in flight
//             hb_done           - per-channel completion pulse
//             clear_status      - clears overrun and timeout_flag
//             hb_start          - one-hot start pulse
//             busy / active_ch  - FSM in START/WAIT, granted channel
//             pending           - pending-request mask
//             overrun           - sticky missed-period flags
//             timeout_flag      - sticky watchdog abort flag
//  Revision : 1.0 - initial release
// ============================================================================
module heartbeat_scheduler #(
    parameter int N_CH    = 3,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 4096,
    localparam int A_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [N_CH*CNT_W-1:0] cfg_period,
    input  logic                  link_idle,
    input  logic [N_CH-1:0]       hb_done,
    input  logic                  clear_status,
    output logic [N_CH-1:0]       hb_start,
    output logic                  busy,
    output logic [A_W-1:0]        active_ch,
    output logic [N_CH-1:0]       pending,
    output logic [N_CH-1:0]       overrun,
    output logic                  timeout_flag
);

    // Watchdog only needs to reach TIMEOUT-1.
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] c_wd_last  = WD_W'(TIMEOUT - 1);
    localparam logic [A_W-1:0]  c_last_rst = A_W'(N_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t           r_state;
    logic [A_W-1:0]   r_active;
    logic [A_W-1:0]   r_last;
    logic [WD_W-1:0]  r_wd;
    logic             r_timeout;
    logic [N_CH-1:0]  r_pending;
    logic [N_CH-1:0]  r_overrun;

    logic [N_CH-1:0]  w_tick;
    logic [N_CH-1:0]  w_clear;     // channel being started this cycle
    logic [N_CH-1:0]  w_waiting;   // channel currently in WAIT
    logic [N_CH-1:0]  w_above;     // channels numbered after the last grant
    logic [N_CH-1:0]  w_masked;
    logic [A_W-1:0]   w_sel;
    logic             w_done;

    // ------------------------------------------------------------------
    // Per-channel period counters and state decodes
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_period;

        assign w_period = cfg_period[i*CNT_W +: CNT_W];
        // '>=' rather than '==' so a period shortened mid-count still expires.
        assign w_tick[i] = enable && (w_period != '0) &&
                           (r_cnt >= w_period - CNT_W'(1));

        always_ff @(posedge clk) begin
            if (rst || !enable || (w_period == '0) || w_tick[i]) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        assign w_clear[i]   = (r_state == S_START) && (r_active == A_W'(i));
        assign w_waiting[i] = (r_state == S_WAIT)  && (r_active == A_W'(i));
        assign w_above[i]   = (A_W'(i) > r_last);
    end

    // ------------------------------------------------------------------
    // Pending requests and overrun flags. A tick always wins over the
    // clear of the same channel; a tick landing on an outstanding request
    // or on the channel being waited on is a missed period.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            r_pending <= enable ? (w_tick | (r_pending & ~w_clear)) : '0;
            r_overrun <= (clear_status ? '0 : r_overrun) |
                         (w_tick & ((r_pending & ~w_clear) | w_waiting));
        end
    end

    // ------------------------------------------------------------------
    // Round-robin select: lowest pending channel above the last grant,
    // otherwise wrap to the lowest pending channel overall.
    // ------------------------------------------------------------------
    assign w_masked = r_pending & w_above;

    always_comb begin
        w_sel = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_sel = A_W'(i);
            end
        end
        if (w_masked != '0) begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (w_masked[i]) begin
                    w_sel = A_W'(i);
                end
            end
        end
    end

    // Only the granted channel's completion counts.
    assign w_done = |(hb_done & w_waiting);

    // ------------------------------------------------------------------
    // Grant FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_active  <= '0;
            r_last    <= c_last_rst;
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (clear_status) begin
                r_timeout <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (link_idle && (r_pending != '0)) begin
                        r_active <= w_sel;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    r_last  <= r_active;
                    // START counts as the first watchdog cycle so the abort
                    // lands exactly TIMEOUT cycles after the start pulse.
                    r_wd    <= WD_W'(1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_done) begin
                        r_state <= S_IDLE;
                    end else if (r_wd == c_wd_last) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign hb_start     = w_clear;
    assign busy         = (r_state != S_IDLE);
    assign active_ch    = r_active;
    assign pending      = r_pending;
    assign overrun      = r_overrun;
    assign timeout_flag = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_heartbeat_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_heartbeat_scheduler
//  Purpose  : Self-checking bench for heartbeat_scheduler. Expected start
//             pulses (channel, cycle) are queued by each scenario and
//             matched as the DUT issues them; a responder returns hb_done
//             a programmable number of cycles after each start.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_heartbeat_scheduler;

    localparam int N_CH    = 3;
    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  enable;
    logic [N_CH*CNT_W-1:0] cfg_period;
    logic                  link_idle;
    logic [N_CH-1:0]       hb_done;
    logic                  clear_status;
    logic [N_CH-1:0]       hb_start;
    logic                  busy;
    logic [1:0]            active_ch;
    logic [N_CH-1:0]       pending;
    logic [N_CH-1:0]       overrun;
    logic                  timeout_flag;

    heartbeat_scheduler #(
        .N_CH    (N_CH),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .cfg_period   (cfg_period),
        .link_idle    (link_idle),
        .hb_done      (hb_done),
        .clear_status (clear_status),
        .hb_start     (hb_start),
        .busy         (busy),
        .active_ch    (active_ch),
        .pending      (pending),
        .overrun      (overrun),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int ch;
        int at;
    } exp_t;
    exp_t exp_q[$];

    int              done_delay = -1;   // -1: never answer a start
    int              done_at    = -1;
    int              done_ch    = 0;
    logic [N_CH-1:0] stray_done = '0;
    int              t0;

    // hb_done driver: responder pulse plus any stray bits a scenario injects
    initial begin : drv_done
        logic [N_CH-1:0] resp;
        hb_done = '0;
        forever begin
            @(posedge clk);
            #3;
            resp = '0;
            if (cyc == done_at) resp[done_ch] = 1'b1;
            hb_done = resp | stray_done;
        end
    end

    // Start monitor / scoreboard
    initial begin : mon
        int   mon_ch;
        exp_t mon_e;
        forever begin
            @(negedge clk);
            if (hb_start !== '0) begin
                mon_ch = -1;
                for (int i = 0; i < N_CH; i++) if (hb_start[i]) mon_ch = i;
                total++;
                if ($countones(hb_start) != 1) begin
                    bad++;
                    $display("FAIL start_onehot got=%b required=one-hot", hb_start);
                end
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL start_unexpected got ch=%0d at cycle %0d required=no start", mon_ch, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    total++;
                    if (mon_ch !== mon_e.ch || cyc !== mon_e.at) begin
                        bad++;
                        $display("FAIL start_order got ch=%0d cyc=%0d required ch=%0d cyc=%0d",
                                 mon_ch, cyc, mon_e.ch, mon_e.at);
                    end
                    total++;
                    if (active_ch !== mon_ch[1:0] || busy !== 1'b1) begin
                        bad++;
                        $display("FAIL start_active got active_ch=%0d busy=%b required active_ch=%0d busy=1",
                                 active_ch, busy, mon_ch);
                    end
                end
                if (done_delay >= 0) begin
                    done_at = cyc + done_delay;
                    done_ch = mon_ch;
                end
            end
        end
    end

    task automatic goto_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_start(input int ch, input int at);
        exp_t e;
        e.ch = ch;
        e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic set_period(input int ch, input int val);
        cfg_period[ch*CNT_W +: CNT_W] = CNT_W'(val);
    endtask

    task automatic apply_reset();
        rst          = 1'b1;
        enable       = 1'b0;
        link_idle    = 1'b0;
        clear_status = 1'b0;
        cfg_period   = '0;
        done_delay   = -1;
        stray_done   = '0;
        goto_cyc(cyc + 2);
        rst = 1'b0;
    endtask

    task automatic check_drained(input string name);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_missing_starts got=%0d outstanding required=0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (hb_start !== '0) begin bad++; $display("FAIL reset_hb_start got=%b required=000", hb_start); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b required=0", busy); end
        total++; if (active_ch !== 2'd0) begin bad++; $display("FAIL reset_active got=%0d required=0", active_ch); end
        total++; if (pending !== '0) begin bad++; $display("FAIL reset_pending got=%b required=000", pending); end
        total++; if (overrun !== '0) begin bad++; $display("FAIL reset_overrun got=%b required=000", overrun); end
        total++; if (timeout_flag !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b required=0", timeout_flag); end
    endtask

    task automatic test_single();
        apply_reset();
        set_period(0, 10);
        link_idle  = 1'b1;
        done_delay = 3;
        t0 = cyc;
        enable = 1'b1;
        push_start(0, t0 + 11);
        push_start(0, t0 + 21);
        push_start(0, t0 + 31);
        goto_cyc(t0 + 10);
        total++; if (pending !== 3'b001) begin bad++; $display("FAIL single_pending got=%b required=001", pending); end
        goto_cyc(t0 + 35);
        enable = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b required=0", busy); end
        total++; if (overrun !== 3'b000) begin bad++; $display("FAIL single_overrun got=%b required=000", overrun); end
        goto_cyc(t0 + 45);
        check_drained("single");
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int c = 0; c < N_CH; c++) set_period(c, 20);
        link_idle  = 1'b1;
        done_delay = 2;
        t0 = cyc;
        enable = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < N_CH; c++)
                push_start(c, t0 + 21 + 20*r + 4*c);
        goto_cyc(t0 + 22);
        total++; if (pending !== 3'b110) begin bad++; $display("FAIL rr_pending got=%b required=110", pending); end
        goto_cyc(t0 + 52);
        enable = 1'b0;
        total++; if (overrun !== 3'b000) begin bad++; $display("FAIL rr_overrun got=%b required=000", overrun); end
        goto_cyc(t0 + 60);
        check_drained("rr");
    endtask

    task automatic test_link_gating();
        apply_reset();
        set_period(0, 10);
        done_delay = 3;
        t0 = cyc;
        enable = 1'b1;
        push_start(0, t0 + 51);
        goto_cyc(t0 + 15);
        total++; if (pending !== 3'b001) begin bad++; $display("FAIL gate_pending got=%b required=001", pending); end
        total++; if (overrun !== 3'b000) begin bad++; $display("FAIL gate_overrun_early got=%b required=000", overrun); end
        goto_cyc(t0 + 25);
        total++; if (overrun !== 3'b001) begin bad++; $display("FAIL gate_overrun got=%b required=001", overrun); end
        goto_cyc(t0 + 50);
        link_idle = 1'b1;
        goto_cyc(t0 + 55);
        enable = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL gate_busy got=%b required=0", busy); end
        goto_cyc(t0 + 62);
        check_drained("gate");
    endtask

    task automatic test_overrun_clear();
        apply_reset();
        set_period(1, 5);
        link_idle  = 1'b1;
        done_delay = 12;
        t0 = cyc;
        enable = 1'b1;
        push_start(1, t0 + 6);
        goto_cyc(t0 + 10);
        total++; if (overrun !== 3'b010 || busy !== 1'b1) begin
            bad++; $display("FAIL ovr_set got overrun=%b busy=%b required overrun=010 busy=1", overrun, busy);
        end
        goto_cyc(t0 + 11);
        clear_status = 1'b1;
        goto_cyc(t0 + 12);
        clear_status = 1'b0;
        total++; if (overrun !== 3'b000) begin bad++; $display("FAIL ovr_clear got=%b required=000", overrun); end
        goto_cyc(t0 + 14);
        clear_status = 1'b1;    // coincides with a tick while waiting
        goto_cyc(t0 + 15);
        clear_status = 1'b0;
        total++; if (overrun !== 3'b010) begin bad++; $display("FAIL ovr_set_wins got=%b required=010", overrun); end
        goto_cyc(t0 + 16);
        enable = 1'b0;
        goto_cyc(t0 + 17);
        total++; if (pending !== 3'b000) begin bad++; $display("FAIL ovr_disable_pending got=%b required=000", pending); end
        goto_cyc(t0 + 19);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovr_done_busy got=%b required=0", busy); end
        goto_cyc(t0 + 25);
        check_drained("ovr");
    endtask

    task automatic test_timeout();
        apply_reset();
        set_period(0, 10);
        link_idle = 1'b1;
        t0 = cyc;
        enable = 1'b1;
        push_start(0, t0 + 11);
        goto_cyc(t0 + 15);
        stray_done = 3'b100;
        goto_cyc(t0 + 16);
        stray_done = '0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL to_stray_done got busy=%b required=1", busy); end
        goto_cyc(t0 + 20);
        enable = 1'b0;
        goto_cyc(t0 + 26);
        total++; if (busy !== 1'b1 || timeout_flag !== 1'b0) begin
            bad++; $display("FAIL to_before got busy=%b flag=%b required busy=1 flag=0", busy, timeout_flag);
        end
        goto_cyc(t0 + 27);
        total++; if (busy !== 1'b0 || timeout_flag !== 1'b1) begin
            bad++; $display("FAIL to_abort got busy=%b flag=%b required busy=0 flag=1", busy, timeout_flag);
        end
        total++; if (overrun !== 3'b001) begin bad++; $display("FAIL to_overrun got=%b required=001", overrun); end
        clear_status = 1'b1;
        goto_cyc(t0 + 28);
        clear_status = 1'b0;
        total++; if (timeout_flag !== 1'b0) begin bad++; $display("FAIL to_clear got=%b required=0", timeout_flag); end
        goto_cyc(t0 + 35);
        check_drained("to");
    endtask

    task automatic test_reset_mid_op();
        apply_reset();
        set_period(1, 10);
        link_idle = 1'b1;
        t0 = cyc;
        enable = 1'b1;
        push_start(1, t0 + 11);
        goto_cyc(t0 + 14);
        rst = 1'b1;
        goto_cyc(t0 + 15);
        total++; if ({hb_start, busy, active_ch, pending, overrun, timeout_flag} !== '0) begin
            bad++; $display("FAIL mid_reset_outputs got start=%b busy=%b act=%0d pend=%b ovr=%b to=%b required all 0",
                            hb_start, busy, active_ch, pending, overrun, timeout_flag);
        end
        rst = 1'b0;
        for (int c = 0; c < N_CH; c++) set_period(c, 10);
        done_delay = 2;
        push_start(0, t0 + 26);
        goto_cyc(t0 + 27);
        total++; if (pending !== 3'b110) begin bad++; $display("FAIL mid_pending got=%b required=110", pending); end
        enable = 1'b0;
        goto_cyc(t0 + 28);
        total++; if (pending !== 3'b000 || busy !== 1'b1) begin
            bad++; $display("FAIL mid_disable got pend=%b busy=%b required pend=000 busy=1", pending, busy);
        end
        goto_cyc(t0 + 29);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_complete got busy=%b required=0", busy); end
        goto_cyc(t0 + 40);
        check_drained("mid");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_link_gating();
        test_overrun_clear();
        test_timeout();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit got=expired required=finish");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
